attack_sequencer: RTL and testbench
===================================

# attack_sequencer

Frame-based attack controller for one fighter. It takes the `attack_enable` grant and the raw attack buttons, then runs the granted attack through startup, active and recovery phases, counting frames on `SCEN` ticks. It drives `attack_busy` back to the player state logic, and drives hitbox and phase information to the game resolver. The game resolver can cancel the attack through `hitstun_active`.

## Interface

Parameters:
- `A1_STARTUP`, default 3: attack1 startup frames.
- `A1_ACTIVE`, default 2: attack1 active (hitbox) frames.
- `A1_RECOVERY`, default 5: attack1 recovery frames.
- `A2_STARTUP`, default 6: attack2 startup frames.
- `A2_ACTIVE`, default 3: attack2 active frames.
- `A2_RECOVERY`, default 10: attack2 recovery frames.
- `CNT_W`, default 4: frame counter width. Every duration must be in 1..2^CNT_W.

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `SCEN`  in  1: one-`clk` frame tick enable.
- `attack_enable`  in  1: grant from player state logic.
- `attack1`  in  1: light attack button, level.
- `attack2`  in  1: heavy attack button, level.
- `hitstun_active`  in  1: from game resolver; aborts the attack.
- `hit_confirm`  in  1: from game resolver; this player's hitbox connected.
- `attack_busy`  out  1: high whenever the state is not IDLE.
- `hitbox_active`  out  1: high in ACTIVE until the first hit is confirmed.
- `attack_id`  out  2: 0 = none, 1 = attack1, 2 = attack2.
- `phase`  out  2: 0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY.
- `hit_landed`  out  1: a hit was confirmed during the current attack.
- `attack_done`  out  1: one-`clk` pulse when recovery completes normally.
- `attack_aborted`  out  1: one-`clk` pulse when hitstun cancels the attack.

## Operation

- State machine: IDLE → STARTUP → ACTIVE → RECOVERY → IDLE.
- All state and counter updates happen only on `clk` edges with `SCEN`=1. The exceptions are the pulse clears and the `hit_confirm` latch.
- Start: in IDLE with `SCEN` & `attack_enable` & (`attack1` | `attack2`) & !`hitstun_active`:
  - latch `attack_id`; attack1 wins if both buttons are pressed;
  - load the counter with STARTUP−1;
  - enter STARTUP.
  - `attack_enable` without a button pressed does nothing.
- Phase advance:
  - On each `SCEN` in a non-IDLE state, if the counter is 0, enter the next phase and load the counter with that phase's duration−1. Otherwise decrement the counter.
  - On leaving RECOVERY: go to IDLE, set `attack_id`←0, clear `hit_landed`, and pulse `attack_done`.
- Hitstun abort:
  - Condition: `SCEN` & `hitstun_active` in any non-IDLE state.
  - Action: go to IDLE, set `attack_id`←0, clear `hit_landed`, pulse `attack_aborted`.
  - This has priority over the phase advance.
  - In IDLE, `hitstun_active` blocks a start.
- Hit confirm:
  - `hit_confirm` is sampled every `clk`, but only while `hitbox_active`=1.
  - It sets `hit_landed`, which drops `hitbox_active` on the next `clk`. This limits each attack to one hit.
  - `hit_confirm` outside ACTIVE is ignored.
- Buttons held after completion do not retrigger by themselves. A new start requires a fresh `attack_enable` on a later `SCEN`. Because `attack_busy` is low in IDLE, the player state logic can grant again on the next frame.
- Phase durations are selected by the latched `attack_id`, never by the live buttons.

## Timing

- Reset values: state IDLE, counter 0, `attack_busy`=0, `hitbox_active`=0, `attack_id`=0, `phase`=0, `hit_landed`=0, `attack_done`=0, `attack_aborted`=0.
- All outputs are registered, or decoded from registered state only. There is no combinational input-to-output path.
- Start latency: `attack_busy` rises and `phase`=1 on the same `clk` edge that samples the start condition.
- `attack_busy` stays high for exactly STARTUP+ACTIVE+RECOVERY `SCEN` ticks.
- `phase`=2 lasts exactly ACTIVE ticks.
- `attack_done` and `attack_aborted` are one `clk` wide. They assert on the terminating edge and clear on the next `clk` regardless of `SCEN`. They never assert together.
- Reset mid-attack: all outputs return to reset values immediately (asynchronous). No done or aborted pulse is generated.
- Hitstun and the final recovery tick on the same `SCEN`: the abort wins, giving `attack_aborted`=1 and `attack_done`=0.

## Structure

- Shared package holds:
  - phase encodings: IDLE, STARTUP, ACTIVE, RECOVERY;
  - attack_id encodings: NONE, ATK1, ATK2;
  - default frame constants, reused by the game resolver for hitbox timing.
- One natural sub-module: `frame_counter`, a loadable down-counter with a `SCEN` enable and a zero flag, `CNT_W` wide. The state machine stays in `attack_sequencer`.

## Test plan

- Attack1 with defaults:
  - Stimulus: `attack_enable`=1, `attack1`=1 on one `SCEN`.
  - Response: `attack_busy` high for 10 ticks; `phase` 1 for 3 ticks, 2 for 2 ticks, 3 for 5 ticks; `attack_done` pulses once at tick 10; `attack_id`=1 throughout.
- Both buttons pressed:
  - Response: `attack_id`=1, with attack1 timing.
  - Then, on a later grant, attack2 alone: busy for 19 ticks, ACTIVE for 3 ticks.
- Hitstun during ACTIVE tick 1 of attack2:
  - Response: IDLE on the same `SCEN` edge, `attack_aborted` pulse, `attack_done`=0, `attack_busy`=0.
- `hit_confirm` during ACTIVE:
  - Response: `hitbox_active` low the next `clk`, `hit_landed`=1 until IDLE.
  - A second `hit_confirm` has no further effect.
  - `hit_confirm` in STARTUP is ignored.
- `reset_n` low during RECOVERY, asynchronous and between clock edges:
  - Response: all outputs go to 0 immediately; no pulses.
  - After release, a fresh grant starts normally.
- Boundary parameters A1 = 1/1/1:
  - Response: busy exactly 3 ticks.
  - Hitstun on the RECOVERY tick gives `attack_aborted` only.

Source files
------------

// File: rtl/attack_sequencer_pkg.sv
// Shared encodings and default frame data for the attack sequencer.
// The game resolver imports the same constants for hitbox timing.
package attack_sequencer_pkg;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_STARTUP  = 2'd1,
    PH_ACTIVE   = 2'd2,
    PH_RECOVERY = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ATK_NONE = 2'd0,
    ATK_ATK1 = 2'd1,
    ATK_ATK2 = 2'd2
  } attack_id_e;

  localparam int A1_STARTUP_DEF  = 3;
  localparam int A1_ACTIVE_DEF   = 2;
  localparam int A1_RECOVERY_DEF = 5;
  localparam int A2_STARTUP_DEF  = 6;
  localparam int A2_ACTIVE_DEF   = 3;
  localparam int A2_RECOVERY_DEF = 10;
  localparam int CNT_W_DEF       = 4;

  // Total frames an attack keeps the fighter busy when it runs to completion.
  function automatic int attack_total_frames(input int startup, input int active,
                                             input int recovery);
    return startup + active + recovery;
  endfunction

endpackage

// File: rtl/attack_sequencer_frame_counter.sv
// Loadable frame down-counter, advancing only on frame ticks.
// Load wins over decrement; the counter holds at zero.
module frame_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (en) begin
      if (load) begin
        cnt_d = load_val;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/attack_sequencer.sv
// Frame-based attack controller: STARTUP -> ACTIVE -> RECOVERY on SCEN ticks,
// with hitstun cancel and a single-hit latch for the resolver.
module attack_sequencer
  import attack_sequencer_pkg::*;
#(
  parameter int A1_STARTUP  = A1_STARTUP_DEF,
  parameter int A1_ACTIVE   = A1_ACTIVE_DEF,
  parameter int A1_RECOVERY = A1_RECOVERY_DEF,
  parameter int A2_STARTUP  = A2_STARTUP_DEF,
  parameter int A2_ACTIVE   = A2_ACTIVE_DEF,
  parameter int A2_RECOVERY = A2_RECOVERY_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCEN,
  input  logic       attack_enable,
  input  logic       attack1,
  input  logic       attack2,
  input  logic       hitstun_active,
  input  logic       hit_confirm,
  output logic       attack_busy,
  output logic       hitbox_active,
  output logic [1:0] attack_id,
  output logic [1:0] phase,
  output logic       hit_landed,
  output logic       attack_done,
  output logic       attack_aborted
);

  // Counter loads hold duration-1 so a zero count means "last frame of phase".
  localparam logic [CNT_W-1:0] A1_S_M1 = CNT_W'(A1_STARTUP - 1);
  localparam logic [CNT_W-1:0] A1_A_M1 = CNT_W'(A1_ACTIVE - 1);
  localparam logic [CNT_W-1:0] A1_R_M1 = CNT_W'(A1_RECOVERY - 1);
  localparam logic [CNT_W-1:0] A2_S_M1 = CNT_W'(A2_STARTUP - 1);
  localparam logic [CNT_W-1:0] A2_A_M1 = CNT_W'(A2_ACTIVE - 1);
  localparam logic [CNT_W-1:0] A2_R_M1 = CNT_W'(A2_RECOVERY - 1);

  phase_e     state_q, state_d;
  attack_id_e id_q, id_d;
  logic       hit_landed_q, hit_landed_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  function automatic logic [CNT_W-1:0] dur_m1(input attack_id_e id, input phase_e ph);
    logic heavy;
    heavy = (id == ATK_ATK2);
    case (ph)
      PH_STARTUP:  return heavy ? A2_S_M1 : A1_S_M1;
      PH_ACTIVE:   return heavy ? A2_A_M1 : A1_A_M1;
      PH_RECOVERY: return heavy ? A2_R_M1 : A1_R_M1;
      default:     return '0;
    endcase
  endfunction

  frame_counter #(
    .CNT_W(CNT_W)
  ) u_frame_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (SCEN),
    .load    (cnt_load),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  assign hitbox_active = (state_q == PH_ACTIVE) && !hit_landed_q;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    hit_landed_d = hit_landed_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_val      = '0;

    // Hit latch runs every clk, independent of the frame tick.
    if (hitbox_active && hit_confirm) begin
      hit_landed_d = 1'b1;
    end

    if (SCEN) begin
      if (state_q == PH_IDLE) begin
        if (attack_enable && (attack1 || attack2) && !hitstun_active) begin
          id_d     = attack1 ? ATK_ATK1 : ATK_ATK2;
          state_d  = PH_STARTUP;
          cnt_load = 1'b1;
          cnt_val  = dur_m1(id_d, PH_STARTUP);
        end
      end else if (hitstun_active) begin
        state_d      = PH_IDLE;
        id_d         = ATK_NONE;
        hit_landed_d = 1'b0;
        aborted_d    = 1'b1;
        cnt_load     = 1'b1;
      end else if (cnt_zero) begin
        cnt_load = 1'b1;
        case (state_q)
          PH_STARTUP: begin
            state_d = PH_ACTIVE;
            cnt_val = dur_m1(id_q, PH_ACTIVE);
          end
          PH_ACTIVE: begin
            state_d = PH_RECOVERY;
            cnt_val = dur_m1(id_q, PH_RECOVERY);
          end
          default: begin
            state_d      = PH_IDLE;
            id_d         = ATK_NONE;
            hit_landed_d = 1'b0;
            done_d       = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PH_IDLE;
      id_q         <= ATK_NONE;
      hit_landed_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      hit_landed_q <= hit_landed_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign attack_busy    = (state_q != PH_IDLE);
  assign attack_id      = id_q;
  assign phase          = state_q;
  assign hit_landed     = hit_landed_q;
  assign attack_done    = done_q;
  assign attack_aborted = aborted_q;

endmodule

// File: tb/tb_attack_sequencer.sv
// Directed bench for attack_sequencer: default timing plus a 1/1/1 attack1 instance.
module tb_attack_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic SCEN = 1'b0;
  logic attack_enable = 1'b0;
  logic attack1 = 1'b0;
  logic attack2 = 1'b0;
  logic hitstun_active = 1'b0;
  logic hit_confirm = 1'b0;

  logic       d_busy, d_hitbox, d_hl, d_done, d_ab;
  logic [1:0] d_id, d_phase;
  logic       s_busy, s_hitbox, s_hl, s_done, s_ab;
  logic [1:0] s_id, s_phase;
  logic [8:0] o_def, o_sml;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  attack_sequencer u_def (
    .clk(clk), .reset_n(reset_n), .SCEN(SCEN), .attack_enable(attack_enable),
    .attack1(attack1), .attack2(attack2), .hitstun_active(hitstun_active),
    .hit_confirm(hit_confirm), .attack_busy(d_busy), .hitbox_active(d_hitbox),
    .attack_id(d_id), .phase(d_phase), .hit_landed(d_hl), .attack_done(d_done),
    .attack_aborted(d_ab)
  );

  attack_sequencer #(.A1_STARTUP(1), .A1_ACTIVE(1), .A1_RECOVERY(1)) u_sml (
    .clk(clk), .reset_n(reset_n), .SCEN(SCEN), .attack_enable(attack_enable),
    .attack1(attack1), .attack2(attack2), .hitstun_active(hitstun_active),
    .hit_confirm(hit_confirm), .attack_busy(s_busy), .hitbox_active(s_hitbox),
    .attack_id(s_id), .phase(s_phase), .hit_landed(s_hl), .attack_done(s_done),
    .attack_aborted(s_ab)
  );

  // Packed view: busy, hitbox, id[1:0], phase[1:0], hit_landed, done, aborted.
  assign o_def = {d_busy, d_hitbox, d_id, d_phase, d_hl, d_done, d_ab};
  assign o_sml = {s_busy, s_hitbox, s_id, s_phase, s_hl, s_done, s_ab};

  function automatic logic [8:0] obs(input bit sml);
    return sml ? o_sml : o_def;
  endfunction

  function automatic logic [8:0] pack(input logic busy, input logic hb, input logic [1:0] id,
                                      input logic [1:0] ph, input logic hl, input logic dn,
                                      input logic ab);
    return {busy, hb, id, ph, hl, dn, ab};
  endfunction

  // All stimulus tasks start and end on a falling clock edge.
  task automatic frame();
    SCEN = 1'b1;
    @(negedge clk);
    SCEN = 1'b0;
  endtask

  task automatic gap();
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic start(input logic a1, input logic a2);
    attack_enable = 1'b1;
    attack1 = a1;
    attack2 = a2;
    frame();
    attack_enable = 1'b0;
  endtask

  // Called right after the start edge; walks the whole attack frame by frame.
  task automatic run_attack(input bit sml, input int s, input int a, input int r,
                            input logic [1:0] id, input string nm);
    int n;
    logic [1:0] ph;
    logic [8:0] exp;
    n = s + a + r;
    for (int i = 0; i < n; i++) begin
      ph = (i < s) ? 2'd1 : (i < s + a) ? 2'd2 : 2'd3;
      exp = pack(1'b1, ph == 2'd2, id, ph, 1'b0, 1'b0, 1'b0);
      total++;
      if (obs(sml) !== exp) begin
        bad++;
        $display("FAIL %s_frame%0d: got %b expected %b", nm, i, obs(sml), exp);
      end
      frame();
    end
    exp = pack(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    total++;
    if (obs(sml) !== exp) begin
      bad++;
      $display("FAIL %s_done: got %b expected %b", nm, obs(sml), exp);
    end
    gap();
    total++;
    if (obs(sml) !== 9'b0) begin
      bad++;
      $display("FAIL %s_done_clear: got %b expected %b", nm, obs(sml), 9'b0);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (o_def !== 9'b0) begin
      bad++;
      $display("FAIL reset_def: got %b expected %b", o_def, 9'b0);
    end
    total++;
    if (o_sml !== 9'b0) begin
      bad++;
      $display("FAIL reset_sml: got %b expected %b", o_sml, 9'b0);
    end
    reset_n = 1'b1;
    gap();
  endtask

  task automatic test_attack1();
    start(1'b1, 1'b0);
    run_attack(1'b0, 3, 2, 5, 2'd1, "atk1");
    frames(3);
    total++;
    if (o_def !== 9'b0) begin
      bad++;
      $display("FAIL held_no_retrigger: got %b expected %b", o_def, 9'b0);
    end
    attack1 = 1'b0;
  endtask

  task automatic test_no_start();
    attack_enable = 1'b1;
    frame();
    total++;
    if (o_def !== 9'b0) begin
      bad++;
      $display("FAIL enable_no_button: got %b expected %b", o_def, 9'b0);
    end
    attack1 = 1'b1;
    hitstun_active = 1'b1;
    frame();
    total++;
    if (o_def !== 9'b0) begin
      bad++;
      $display("FAIL hitstun_blocks_start: got %b expected %b", o_def, 9'b0);
    end
    attack_enable = 1'b0;
    hitstun_active = 1'b0;
    attack1 = 1'b0;
    gap();
  endtask

  task automatic test_both_buttons();
    start(1'b1, 1'b1);
    run_attack(1'b0, 3, 2, 5, 2'd1, "both");
    attack1 = 1'b0;
    start(1'b0, 1'b1);
    run_attack(1'b0, 6, 3, 10, 2'd2, "atk2");
    attack2 = 1'b0;
  endtask

  task automatic test_hitstun_abort();
    logic [8:0] exp;
    start(1'b0, 1'b1);
    attack2 = 1'b0;
    frames(6);
    exp = pack(1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_def !== exp) begin
      bad++;
      $display("FAIL atk2_active1: got %b expected %b", o_def, exp);
    end
    hitstun_active = 1'b1;
    frame();
    hitstun_active = 1'b0;
    exp = pack(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    total++;
    if (o_def !== exp) begin
      bad++;
      $display("FAIL abort_in_active: got %b expected %b", o_def, exp);
    end
    gap();
    total++;
    if (o_def !== 9'b0) begin
      bad++;
      $display("FAIL abort_clear: got %b expected %b", o_def, 9'b0);
    end
  endtask

  task automatic test_hit_confirm();
    logic [8:0] exp;
    start(1'b1, 1'b0);
    attack1 = 1'b0;
    hit_confirm = 1'b1;
    gap();
    hit_confirm = 1'b0;
    exp = pack(1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_def !== exp) begin
      bad++;
      $display("FAIL hc_in_startup: got %b expected %b", o_def, exp);
    end
    frames(3);
    exp = pack(1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_def !== exp) begin
      bad++;
      $display("FAIL hc_active_start: got %b expected %b", o_def, exp);
    end
    hit_confirm = 1'b1;
    gap();
    hit_confirm = 1'b0;
    exp = pack(1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
    total++;
    if (o_def !== exp) begin
      bad++;
      $display("FAIL hc_drops_hitbox: got %b expected %b", o_def, exp);
    end
    hit_confirm = 1'b1;
    gap();
    hit_confirm = 1'b0;
    total++;
    if (o_def !== exp) begin
      bad++;
      $display("FAIL hc_second: got %b expected %b", o_def, exp);
    end
    frame();
    total++;
    if (o_def !== exp) begin
      bad++;
      $display("FAIL hc_active2: got %b expected %b", o_def, exp);
    end
    frame();
    exp = pack(1'b1, 1'b0, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0);
    total++;
    if (o_def !== exp) begin
      bad++;
      $display("FAIL hl_in_recovery: got %b expected %b", o_def, exp);
    end
    frames(4);
    total++;
    if (o_def !== exp) begin
      bad++;
      $display("FAIL hl_last_recovery: got %b expected %b", o_def, exp);
    end
    frame();
    exp = pack(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    total++;
    if (o_def !== exp) begin
      bad++;
      $display("FAIL hc_done_clears_hl: got %b expected %b", o_def, exp);
    end
    gap();
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    start(1'b1, 1'b0);
    attack1 = 1'b0;
    frames(6);
    exp = pack(1'b1, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_def !== exp) begin
      bad++;
      $display("FAIL pre_reset_recovery: got %b expected %b", o_def, exp);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (o_def !== 9'b0) begin
      bad++;
      $display("FAIL async_reset: got %b expected %b", o_def, 9'b0);
    end
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (o_def !== 9'b0) begin
      bad++;
      $display("FAIL no_pulse_after_reset: got %b expected %b", o_def, 9'b0);
    end
    start(1'b1, 1'b0);
    attack1 = 1'b0;
    run_attack(1'b0, 3, 2, 5, 2'd1, "post_reset");
  endtask

  task automatic test_boundary();
    logic [8:0] exp;
    reset_n = 1'b0;
    gap();
    reset_n = 1'b1;
    gap();
    start(1'b1, 1'b0);
    attack1 = 1'b0;
    run_attack(1'b1, 1, 1, 1, 2'd1, "small");
    start(1'b1, 1'b0);
    attack1 = 1'b0;
    frames(2);
    exp = pack(1'b1, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_sml !== exp) begin
      bad++;
      $display("FAIL small_recovery: got %b expected %b", o_sml, exp);
    end
    hitstun_active = 1'b1;
    frame();
    hitstun_active = 1'b0;
    exp = pack(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    total++;
    if (o_sml !== exp) begin
      bad++;
      $display("FAIL small_abort_wins: got %b expected %b", o_sml, exp);
    end
    gap();
    total++;
    if (o_sml !== 9'b0) begin
      bad++;
      $display("FAIL small_abort_clear: got %b expected %b", o_sml, 9'b0);
    end
  endtask

  initial begin
    test_reset();
    test_attack1();
    test_no_start();
    test_both_buttons();
    test_hitstun_abort();
    test_hit_confirm();
    test_reset_mid();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
